// File: rtl/comparator_bist.sv
// Built-in self-test engine for a WIDTH-bit magnitude comparator.
// Sweeps every (A,B) operand pair, settles, then checks the gt/lt/eq flags.
//
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   start             begin a sweep (honoured only in IDLE or DONE)
//   a_out, b_out      registered operands driven to the comparator
//   a_gt_b_in         comparator flag A>B
//   a_lt_b_in         comparator flag A<B
//   a_eq_b_in         comparator flag A==B
//   busy              sweep in progress
//   done              sweep complete, held until next start or reset
//   pass              done with zero errors
//   err_count         number of failing pairs
//   fail_valid        first_fail_a/b hold a captured failure
//   first_fail_a/b    operands of the first failing pair
module comparator_bist #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    input  logic               a_gt_b_in,
    input  logic               a_lt_b_in,
    input  logic               a_eq_b_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic               fail_valid,
    output logic [WIDTH-1:0]   first_fail_a,
    output logic [WIDTH-1:0]   first_fail_b
);

    localparam int IW = 2 * WIDTH;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = {IW{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic [IW:0]     r_err;
    logic            r_fail_valid;
    logic [WIDTH-1:0] r_ff_a;
    logic [WIDTH-1:0] r_ff_b;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [2:0]       w_exp;
    logic [2:0]       w_got;
    logic             w_mismatch;
    logic [IW:0]      w_err_next;
    logic [IW-1:0]    w_idx_next;

    // The operands are the two halves of the sweep index, so they are
    // registered by construction: A is the MSB field, B the LSB field.
    assign w_a = r_idx[IW-1:WIDTH];
    assign w_b = r_idx[WIDTH-1:0];

    // Any flag differing from the reference counts, so non-one-hot
    // responses such as 000 or 110 are caught as well.
    assign w_exp      = {w_a > w_b, w_a < w_b, w_a == w_b};
    assign w_got      = {a_gt_b_in, a_lt_b_in, a_eq_b_in};
    assign w_mismatch = (w_exp != w_got);
    assign w_err_next = r_err + {{IW{1'b0}}, w_mismatch};
    assign w_idx_next = r_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_ff_a       <= '0;
            r_ff_b       <= '0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state      <= S_SETTLE;
                        r_idx        <= '0;
                        r_cnt        <= '0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_err        <= '0;
                        r_fail_valid <= 1'b0;
                        r_ff_a       <= '0;
                        r_ff_b       <= '0;
                    end
                end

                S_SETTLE: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_CHECK: begin
                    r_err <= w_err_next;
                    if (w_mismatch && !r_fail_valid) begin
                        r_fail_valid <= 1'b1;
                        r_ff_a       <= w_a;
                        r_ff_b       <= w_b;
                    end
                    if (r_idx != IDX_LAST) begin
                        r_idx   <= w_idx_next;
                        r_cnt   <= '0;
                        r_state <= S_SETTLE;
                    end else begin
                        // Last pair: the verdict includes this check.
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign a_out        = w_a;
    assign b_out        = w_b;
    assign busy         = r_busy;
    assign done         = r_done;
    assign pass         = r_pass;
    assign err_count    = r_err;
    assign fail_valid   = r_fail_valid;
    assign first_fail_a = r_ff_a;
    assign first_fail_b = r_ff_b;

endmodule

// File: tb/tb_comparator_bist.sv
// Directed testbench for comparator_bist with a behavioural comparator
// that can be made faulty (eq stuck at 0, gt/lt swapped).
module tb_comparator_bist;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       start3;
    logic [1:0] mode;

    logic [3:0] a_out, b_out, a3, b3;
    logic       gt, lt, eq, gt3, lt3, eq3;
    logic       busy, done, pass, fv;
    logic       busy3, done3, pass3, fv3;
    logic [8:0] err, err3;
    logic [3:0] ffa, ffb, ffa3, ffb3;

    int n_cmp = 0;
    int n_err = 0;
    int n;

    always #5 clk = ~clk;

    // mode 0: correct, 1: eq stuck at 0, 2: gt/lt swapped
    function automatic logic [2:0] cmp_model(input logic [1:0] m,
                                             input logic [3:0] a,
                                             input logic [3:0] b);
        logic g, l, e;
        g = (a > b);
        l = (a < b);
        e = (a == b);
        if (m == 2'd1) e = 1'b0;
        if (m == 2'd2) return {l, g, e};
        return {g, l, e};
    endfunction

    assign {gt, lt, eq}    = cmp_model(mode, a_out, b_out);
    assign {gt3, lt3, eq3} = cmp_model(2'd0, a3, b3);

    comparator_bist #(.WIDTH(4), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_out(a_out), .b_out(b_out),
        .a_gt_b_in(gt), .a_lt_b_in(lt), .a_eq_b_in(eq),
        .busy(busy), .done(done), .pass(pass), .err_count(err),
        .fail_valid(fv), .first_fail_a(ffa), .first_fail_b(ffb)
    );

    comparator_bist #(.WIDTH(4), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .a_out(a3), .b_out(b3),
        .a_gt_b_in(gt3), .a_lt_b_in(lt3), .a_eq_b_in(eq3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_valid(fv3), .first_fail_a(ffa3), .first_fail_b(ffb3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge (edge E), then count cycles until done.
    task automatic run_sweep(output int cyc);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 3000) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        start3 = 1'b0;
        mode   = 2'd0;
        tick();
        tick();

        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err, 0);
        chk("rst_fv", fv, 0);
        chk("rst_ab", {a_out, b_out}, 0);
        chk("rst_ff", {ffa, ffb}, 0);

        rst_n = 1'b1;
        tick();
        chk("idle_hold", {busy, done}, 0);

        // Correct comparator
        run_sweep(n);
        chk("good_cycles", n, 512);
        chk("good_done", done, 1);
        chk("good_busy", busy, 0);
        chk("good_pass", pass, 1);
        chk("good_err", err, 0);
        chk("good_fv", fv, 0);
        tick();
        tick();
        chk("good_ab_hold", {a_out, b_out}, 8'hFF);
        chk("good_done_hold", {done, pass}, 2'b11);

        // eq stuck at 0
        mode = 2'd1;
        run_sweep(n);
        chk("eq0_cycles", n, 512);
        chk("eq0_err", err, 16);
        chk("eq0_pass", pass, 0);
        chk("eq0_fv", fv, 1);
        chk("eq0_ffa", ffa, 0);
        chk("eq0_ffb", ffb, 0);

        // gt/lt swapped
        mode = 2'd2;
        run_sweep(n);
        chk("swap_cycles", n, 512);
        chk("swap_err", err, 240);
        chk("swap_pass", pass, 0);
        chk("swap_ffa", ffa, 0);
        chk("swap_ffb", ffb, 1);

        // Restart from DONE after a failing run, correct model
        mode  = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("re_err_clr", err, 0);
        chk("re_fv_clr", fv, 0);
        chk("re_busy", {busy, done, pass}, 3'b100);
        n = 0;
        while (!done && n < 3000) begin
            tick();
            n++;
        end
        chk("re_cycles", n, 512);
        chk("re_pass", pass, 1);

        // Reset in the middle of a sweep
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 199; i++) tick();
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mr_busy", busy, 0);
        chk("mr_done", {done, pass}, 0);
        chk("mr_err", {err, fv}, 0);
        chk("mr_ab", {a_out, b_out, ffa, ffb}, 0);
        tick();
        chk("mr_idle", {busy, a_out, b_out}, 0);
        run_sweep(n);
        chk("mr_cycles", n, 512);
        chk("mr_pass", pass, 1);

        // SETTLE_CYCLES=3 sequencing
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        chk("s3_pair0", {busy3, a3, b3}, 9'h100);
        n = 0;
        while (b3 != 4'd1 && n < 20) begin
            tick();
            n++;
        end
        chk("s3_pair1_at", n, 4);
        chk("s3_a_pair1", a3, 0);
        while (!done3 && n < 3000) begin
            tick();
            n++;
            start3 = (n == 100);
        end
        start3 = 1'b0;
        chk("s3_cycles", n, 1024);
        chk("s3_pass", {pass3, err3}, 10'h200);
        chk("s3_ab_end", {a3, b3}, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/comparator_bist.md
Name: comparator_bist

Overview:
Built-in self-test engine that drives the A/B operand inputs of a magnitude comparator and checks its gt/lt/eq flags.
- On start it sweeps every operand pair exhaustively.
- For each pair it waits a programmable settle time, then samples the three flags and compares them with the expected result.
- It reports an error count and the first failing pair.
- It sits between the test controller and any WIDTH-bit comparator instance. It is the driving and checking end of the comparator interface.

Parameters:
WIDTH, 4, operand width in bits; sweep covers 2^(2*WIDTH) pairs
SETTLE_CYCLES, 1, cycles the operands are held before flags are sampled; must be >= 1

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  begin a sweep; sampled only in IDLE or DONE
a_out  output  WIDTH  operand A to comparator, registered
b_out  output  WIDTH  operand B to comparator, registered
a_gt_b_in  input  1  comparator flag A>B
a_lt_b_in  input  1  comparator flag A<B
a_eq_b_in  input  1  comparator flag A==B
busy  output  1  sweep in progress
done  output  1  sweep complete; held until next start or reset
pass  output  1  done and err_count==0
err_count  output  2*WIDTH+1  number of failing pairs, unsigned
fail_valid  output  1  first_fail_a/b hold a captured failure
first_fail_a  output  WIDTH  A of first failing pair
first_fail_b  output  WIDTH  B of first failing pair

Behaviour:
- Reset (rst_n=0 at a rising edge, any state, including mid-sweep):
  - state=IDLE.
  - All outputs 0: a_out, b_out, busy, done, pass, err_count, fail_valid, first_fail_a, first_fail_b.
  - Internal index and settle counter are cleared.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE with start=1, at edge E:
  - idx=0, a_out=0, b_out=0, err_count=0, fail_valid=0, first_fail_a/b=0.
  - done=0, pass=0, busy=1, settle counter=0, go to SETTLE.
  - With start=0 the state is held; DONE keeps its results.
- SETTLE:
  - Counter increments each cycle.
  - When it reaches SETTLE_CYCLES-1, go to CHECK the next edge.
  - Operands are held stable for exactly SETTLE_CYCLES cycles before CHECK.
- CHECK (one cycle): flags are sampled combinationally against a_out/b_out.
  - Expected values: gt=(a_out>b_out), lt=(a_out<b_out), eq=(a_out==b_out), all unsigned.
  - A mismatch is any of the three flags differing from its expected value. This covers non-one-hot outputs such as 000 and 110.
  - On mismatch: err_count+1. If fail_valid=0, capture first_fail_a=a_out, first_fail_b=b_out, fail_valid=1.
  - If idx != 2^(2*WIDTH)-1: idx+1, a_out = new idx[2W-1:W], b_out = new idx[W-1:0], counter=0, go to SETTLE.
  - Else: go to DONE, busy=0, done=1, and pass=1 iff the final err_count==0 (including this cycle's check).
- Sweep order: A is the MSB field and B the LSB field. Pairs run (0,0),(0,1)...(0,F),(1,0)...(F,F).
- Timing:
  - Pair k is driven from edge E+k*(SETTLE_CYCLES+1).
  - done rises at edge E+2^(2*WIDTH)*(SETTLE_CYCLES+1), i.e. 512 cycles for the defaults.
- start while busy is ignored; it does not restart or extend the sweep.
- err_count width fits the maximum 2^(2*WIDTH), so no saturation is needed and no wrap can occur.
- Flag inputs are ignored outside CHECK.

Test Plan:
- Reset then start=1 for 1 cycle, correct comparator model attached, defaults -> busy=1 for 512 cycles; done=1, pass=1, err_count=0, fail_valid=0; a_out/b_out stay F/F after done.
- Comparator with a_eq_b stuck at 0 -> done after 512 cycles; err_count=16, pass=0, fail_valid=1, first_fail_a=0, first_fail_b=0.
- Comparator with gt/lt swapped -> err_count=240, first_fail_a=0, first_fail_b=1.
- Sequencing check with SETTLE_CYCLES=3 -> pair (0,1) appears 4 cycles after (0,0); done at 1024 cycles; start pulsed at cycle 100 has no effect.
- rst_n=0 for 1 cycle at cycle 200 of a sweep -> next cycle all outputs 0 and state IDLE; a new start runs a full 512-cycle sweep.
- Second start while in DONE after a failing run, now with a correct model -> err_count and fail_valid clear at the start edge; final pass=1.
